// File: rtl/score_display.sv
// score_display: converts a 14-bit binary score to four BCD digits and scans
// them onto a multiplexed active-low 7-segment display.
// A score above 9999 is shown as 9999.
// Optional leading-zero blanking is built when SCORE_DISPLAY_BLANK_EN is defined.
module score_display #(
   parameter int unsigned REFRESH_BITS = 17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] score,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      LOAD
   } state_t;

   localparam logic [13:0] MAX_SHOWN = 14'd9999;
   localparam logic [3:0]  LAST_STEP = 4'd13;

   state_t                  state;
   state_t                  state_nxt;
   logic                    start;
   logic [13:0]             last_score;
   logic [13:0]             bin;
   logic [15:0]             bcd;
   logic [15:0]             bcd_adj;
   logic [15:0]             disp;
   logic [3:0]              step;
   logic [REFRESH_BITS-1:0] refresh;
   logic [1:0]              idx;
   logic [3:0]              digit;
   logic                    blank;

   // Map one BCD nibble to active-low segments (bit0=a .. bit6=g).
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Conversion FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: start on a score change, 14 shift steps, then load.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (score != last_score) begin
               start     = 1'b1;
               state_nxt = CONVERT;
            end
         end
         CONVERT: if (step == LAST_STEP) state_nxt = LOAD;
         LOAD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift.
   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // Conversion datapath: latch and clamp, shift-add-3, then commit to the display.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_score <= '0;
         bin        <= '0;
         bcd        <= '0;
         step       <= '0;
         disp       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  last_score <= score;
                  bin        <= (score > MAX_SHOWN) ? MAX_SHOWN : score;
                  bcd        <= '0;
                  step       <= '0;
               end
            end
            CONVERT: begin
               {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
               step       <= step + 4'd1;
            end
            LOAD:    disp <= bcd;
            default: ;
         endcase
      end
   end

   // Free-running refresh counter; the digit index advances on each wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh <= '0;
         idx     <= '0;
      end else begin
         refresh <= refresh + 1'b1;
         if (&refresh) idx <= idx + 2'd1;
      end
   end

   // Select the digit currently being scanned.
   always_comb begin
      digit = 4'd0;
      case (idx)
         2'd0: digit = disp[3:0];
         2'd1: digit = disp[7:4];
         2'd2: digit = disp[11:8];
         2'd3: digit = disp[15:12];
         default: digit = 4'd0;
      endcase
   end

`ifdef SCORE_DISPLAY_BLANK_EN
   // Blank a digit when it and every more significant digit are zero; never the ones digit.
   always_comb begin
      blank = 1'b0;
      case (idx)
         2'd1: blank = (disp[15:4] == 12'd0);
         2'd2: blank = (disp[15:8] == 8'd0);
         2'd3: blank = (disp[15:12] == 4'd0);
         default: blank = 1'b0;
      endcase
   end
`else
   // Every digit is decoded, leading zeros included.
   always_comb begin
      blank = 1'b0;
   end
`endif

   // Registered display outputs, one cycle behind the digit index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg <= 7'h7F;
         an  <= 4'hF;
      end else begin
         an  <= ~(4'b0001 << idx);
         seg <= blank ? 7'h7F : decode(digit);
      end
   end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter REFRESH_BITS, default 17: width of the free-running refresh counter; the digit advances on each counter wrap.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 score  input  14  binary score from the scoring block, 0..16383.
REQ-005 seg  output  7  active-low segments; bit0=a .. bit6=g.
REQ-006 an  output  4  active-low digit enables; an[0]=ones, an[3]=thousands.
REQ-007 busy  output  1  high while a conversion is in progress.

Function
REQ-008 The block SHALL use FSM states IDLE, CONVERT and LOAD.
REQ-009 IDLE: on an edge where score != last_score, the block SHALL latch last_score<=score and clamp the working value to min(score,9999), then go to CONVERT.
REQ-010 CONVERT SHALL run exactly 14 cycles of shift-add-3: on each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1.
REQ-011 LOAD SHALL copy the 4 BCD nibbles atomically into the display register, then return to IDLE.
REQ-012 Latency: if the latch occurs on edge E, shifts occur on E+1..E+14 and the display register updates on E+15.
REQ-013 busy SHALL be high from edge E through edge E+15 (CONVERT and LOAD) and low in IDLE.
REQ-014 Score changes while busy SHALL be ignored. On return to IDLE, a score differing from last_score SHALL trigger a new conversion on the next edge.
REQ-015 The display register SHALL never show partial or intermediate BCD values.
REQ-016 A scores above 9999 SHALL display 9999; last_score SHALL still hold the raw value.
REQ-017 Refresh counter: REFRESH_BITS wide, free-running, wrapping modulo 2^REFRESH_BITS.
REQ-018 Digit index: 2 bits, increments on counter wrap, wraps from 3 to 0.
REQ-019 Outputs SHALL be registered with a 1-cycle delay after the index: an = ~(1<<idx), seg = decode(digit[idx]).
REQ-020 Decode table, hex seg values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-021 Nibble values 10..15 SHALL decode to 7F (blank); they are unreachable in normal operation.

Reset
REQ-022 While reset is asserted: state=IDLE, last_score=0, display register=0000, counter=0, idx=0, seg=7F, an=F, busy=0.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion with no display update.
REQ-024 After reset release, the first edge SHALL drive an=E and seg=40.
REQ-025 If score != 0 after reset release, a conversion SHALL start on the first edge.

Configuration
REQ-026 Macro SCORE_DISPLAY_BLANK_EN, when defined, SHALL enable leading-zero blanking: any digit more significant than the most significant nonzero digit outputs seg=7F. Its anode still scans; the ones digit is never blanked.
REQ-027 When SCORE_DISPLAY_BLANK_EN is undefined, all four digits SHALL always be decoded, including leading zeros.

Verification (REFRESH_BITS=2 for all scenarios)
REQ-028 Reset held with score=0 -> seg=7F, an=F, busy=0; after release -> digits cycle an=E,D,B,7, with seg=40 on each digit (no blank macro).
REQ-029 score 0->1234 -> busy high for exactly 16 edges; then an=E:seg=19, an=D:seg=30, an=B:seg=24, an=7:seg=79.
REQ-030 score=12000 -> display 9999, seg=10 on all digits; busy pulses once.
REQ-031 score=5, then 6 at E+5 -> display shows 5, busy drops, reconversion starts on the next edge, display shows 6; no other value ever appears.
REQ-032 SCORE_DISPLAY_BLANK_EN defined, score=7 -> an=E:seg=78, other digits seg=7F. Macro undefined -> other digits seg=40.
REQ-033 Reset pulsed at E+7 of a 4321 conversion -> busy=0, display 0000. With score held at 4321, conversion restarts after release and displays 4321.
